dcache_ctrl: RTL

Direct-mapped, write-through, no-write-allocate data cache controller for the memory stage of the 5-stage pipeline. It serves load/store requests from the EX/MEM register, refills lines from the backing memory over a req/ack handshake, and drives `cache_busy` to the hazard unit. The hazard unit uses `cache_busy` to stall fetch and decode and to flush execute until the request completes.

---
 rtl/dcache_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the memory stage.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic [31:0] rdata,
   output logic        cache_busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int WB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(SETS);
   localparam int TW = 30 - WB - IB;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

   state_t state, nxt;
   logic [WB-1:0]                          cnt;
   logic [SETS-1:0]                        valid;
   logic [SETS-1:0][TW-1:0]                tags;
   logic [SETS-1:0][LINE_WORDS-1:0][31:0]  data;

   logic [WB-1:0] word;
   logic [IB-1:0] index;
   logic [TW-1:0] tag;
   logic          line_match, last;
   logic          unused_ok;

   assign word       = req_addr[2 +: WB];
   assign index      = req_addr[2+WB +: IB];
   assign tag        = req_addr[31 -: TW];
   assign line_match = valid[index] && (tags[index] == tag);
   assign last       = (cnt == WB'(LINE_WORDS-1));
   assign rdata      = data[index][word];
   assign unused_ok  = ^req_addr[1:0];

   always_comb begin
      nxt        = state;
      cache_busy = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_be     = '0;
      case (state)
         IDLE: begin
            if (req_valid && req_we) begin
               cache_busy = 1'b1;
               nxt        = WRITE;
            end else if (req_valid && !line_match) begin
               cache_busy = 1'b1;
               nxt        = REFILL;
            end
         end
         REFILL: begin
            cache_busy = 1'b1;
            mem_req    = 1'b1;
            mem_addr   = {req_addr[31:2+WB], cnt, 2'b00};
            if (mem_ack && last) nxt = IDLE;
         end
         WRITE: begin
            cache_busy = 1'b1;
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = {req_addr[31:2], 2'b00};
            mem_wdata  = req_wdata;
            mem_be     = req_be;
            if (mem_ack) nxt = WDONE;
         end
         // one non-busy cycle lets the pipeline retire the store without re-issuing it
         WDONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         valid <= '0;
         tags  <= '0;
         data  <= '0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: begin
               if (req_valid && !req_we && !line_match) begin
                  valid[index] <= 1'b0;
                  cnt          <= '0;
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  data[index][cnt] <= mem_rdata;
                  cnt              <= cnt + WB'(1);
                  if (last) begin
                     valid[index] <= 1'b1;
                     tags[index]  <= tag;
                  end
               end
            end
            WRITE: begin
               if (mem_ack && line_match) begin
                  for (int b = 0; b < 4; b++)
                     if (req_be[b]) data[index][word][8*b +: 8] <= req_wdata[8*b +: 8];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   // store hits update the line but count as neither hit nor miss
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && req_valid) begin
         if (!req_we && line_match) hit_count  <= hit_count + 32'd1;
         else if (!line_match)      miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule
